// File: rtl/gpio_test_monitor_pkg.sv
// gpio_test_monitor_pkg: shared FSM encodings and default firmware signatures
package gpio_test_monitor_pkg;
    typedef enum logic [2:0] {
        ST_ARM     = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;
    localparam logic [7:0] DEF_PASS_CODE = 8'hA5;
    localparam logic [7:0] DEF_FAIL_CODE = 8'hE0;
endpackage

// File: rtl/gpio_test_monitor_sat_counter.sv
// sat_counter: up counter saturating at MAX; clr loads 0, or 1 when inc is also high
// Ports: clk, reset (async, active-high), clr, inc, value
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) value <= '0;
        else if (clr) value <= WIDTH'(inc);
        else if (inc && value < TOP) value <= value + WIDTH'(1);
    end
endmodule

// File: rtl/gpio_test_monitor.sv
// gpio_test_monitor: watches gpio for stable pass/fail signatures under a RUN-cycle budget
// Ports: clk, reset (async, active-high), gpio (observed bus), enable (budget advances),
//        state/done/pass/fail/timeout (registered status), cycle_count, change_count
module gpio_test_monitor
    import gpio_test_monitor_pkg::*;
#(
    parameter int                    GPIO_WIDTH    = 8,
    parameter int                    CNT_WIDTH     = 32,
    parameter int                    MAX_CYCLES    = 1000,
    parameter int                    ARM_DELAY     = 4,
    parameter int                    STABLE_CYCLES = 2,
    parameter logic [GPIO_WIDTH-1:0] PASS_CODE     = GPIO_WIDTH'(DEF_PASS_CODE),
    parameter logic [GPIO_WIDTH-1:0] FAIL_CODE     = GPIO_WIDTH'(DEF_FAIL_CODE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [GPIO_WIDTH-1:0] gpio,
    input  logic                  enable,
    output logic [2:0]            state,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [15:0]           change_count
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    // +2 keeps the arm counter at least one bit wide when ARM_DELAY is 0
    localparam int AW = $clog2(ARM_DELAY + 2);
    state_t                st;
    logic [GPIO_WIDTH-1:0] gpio_q;
    logic [SW-1:0]         stable_cnt;
    logic [AW-1:0]         arm_cnt;
    logic                  changed, in_run, held, hit_pass, hit_fail, expire;
    assign changed  = gpio != gpio_q;
    assign in_run   = st == ST_RUN;
    assign held     = stable_cnt >= SW'(STABLE_CYCLES);
    assign hit_pass = held && gpio_q == PASS_CODE;
    assign hit_fail = held && gpio_q == FAIL_CODE;
    assign expire   = enable && cycle_count == CNT_WIDTH'(MAX_CYCLES - 1);
    assign state    = st;
    // the expiry edge itself also counts, landing cycle_count on MAX_CYCLES
    sat_counter #(.WIDTH(CNT_WIDTH), .MAX(MAX_CYCLES)) u_cycle (
        .clk(clk), .reset(reset), .clr(1'b0),
        .inc(in_run && enable && !hit_pass && !hit_fail), .value(cycle_count)
    );
    sat_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_change (
        .clk(clk), .reset(reset), .clr(1'b0), .inc(in_run && changed), .value(change_count)
    );
    // a fresh value restarts the run length at 1 (clr with inc)
    sat_counter #(.WIDTH(SW), .MAX(STABLE_CYCLES)) u_stable (
        .clk(clk), .reset(reset), .clr(changed), .inc(1'b1), .value(stable_cnt)
    );
    sat_counter #(.WIDTH(AW), .MAX(ARM_DELAY)) u_arm (
        .clk(clk), .reset(reset), .clr(1'b0), .inc(st == ST_ARM), .value(arm_cnt)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= ST_ARM;
            gpio_q  <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
            fail    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            gpio_q <= gpio;
            case (st)
                ST_ARM: if (arm_cnt == AW'(ARM_DELAY)) st <= ST_RUN;
                ST_RUN:
                    if (hit_pass) begin
                        st   <= ST_PASS;
                        pass <= 1'b1;
                        done <= 1'b1;
                    end else if (hit_fail) begin
                        st   <= ST_FAIL;
                        fail <= 1'b1;
                        done <= 1'b1;
                    end else if (expire) begin
                        st      <= ST_TIMEOUT;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_test_monitor.sv
// tb_gpio_test_monitor: randomized checks of three monitor configurations against a behavioural model
module tb_gpio_test_monitor;
    import gpio_test_monitor_pkg::*;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst[3];
    logic        en[3];
    logic [15:0] g[3];
    logic [2:0]  st0, st1, st2;
    logic        dn0, dn1, dn2, ps0, ps1, ps2, fl0, fl1, fl2, to0, to1, to2;
    logic [31:0] cc0, cc1, cc2;
    logic [15:0] ch0, ch1, ch2;
    logic [54:0] obs[3];
    int errs = 0;
    int checks = 0;
    localparam int          P_MAX[3]  = '{1000, 10, 1000};
    localparam int          P_ARM[3]  = '{4, 4, 0};
    localparam int          P_STB[3]  = '{2, 2, 1};
    localparam logic [15:0] P_PASS[3] = '{{8'h00, DEF_PASS_CODE}, {8'h00, DEF_PASS_CODE}, 16'hCAFE};
    localparam logic [15:0] P_FAIL[3] = '{{8'h00, DEF_FAIL_CODE}, {8'h00, DEF_FAIL_CODE}, 16'hBEEF};

    gpio_test_monitor d0 (
        .clk(clk), .reset(rst[0]), .gpio(g[0][7:0]), .enable(en[0]), .state(st0), .done(dn0),
        .pass(ps0), .fail(fl0), .timeout(to0), .cycle_count(cc0), .change_count(ch0)
    );
    gpio_test_monitor #(.MAX_CYCLES(10)) d1 (
        .clk(clk), .reset(rst[1]), .gpio(g[1][7:0]), .enable(en[1]), .state(st1), .done(dn1),
        .pass(ps1), .fail(fl1), .timeout(to1), .cycle_count(cc1), .change_count(ch1)
    );
    gpio_test_monitor #(.GPIO_WIDTH(16), .ARM_DELAY(0), .STABLE_CYCLES(1),
                        .PASS_CODE(16'hCAFE), .FAIL_CODE(16'hBEEF)) d2 (
        .clk(clk), .reset(rst[2]), .gpio(g[2]), .enable(en[2]), .state(st2), .done(dn2),
        .pass(ps2), .fail(fl2), .timeout(to2), .cycle_count(cc2), .change_count(ch2)
    );
    assign obs[0] = {st0, dn0, ps0, fl0, to0, cc0, ch0};
    assign obs[1] = {st1, dn1, ps1, fl1, to1, cc1, ch1};
    assign obs[2] = {st2, dn2, ps2, fl2, to2, cc2, ch2};

    // Reference model: tracks the last sample and its run length, and applies the
    // arm / detect / budget rules to each edge in priority order.
    int          m_st[3], m_arm[3], m_cyc[3], m_chg[3], m_run[3];
    logic [15:0] m_q[3];
    always @(posedge clk) begin : model
        bit ch, hold;
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                m_st[i] = 0; m_arm[i] = 0; m_cyc[i] = 0; m_chg[i] = 0; m_run[i] = 0; m_q[i] = '0;
            end else begin
                ch   = g[i] != m_q[i];
                hold = m_run[i] >= P_STB[i];
                if (m_st[i] == 0) begin
                    if (m_arm[i] == P_ARM[i]) m_st[i] = 1;
                    else m_arm[i]++;
                end else if (m_st[i] == 1) begin
                    if (ch && m_chg[i] < 65535) m_chg[i]++;
                    if (hold && m_q[i] == P_PASS[i]) m_st[i] = 2;
                    else if (hold && m_q[i] == P_FAIL[i]) m_st[i] = 3;
                    else if (en[i]) begin
                        m_cyc[i]++;
                        if (m_cyc[i] == P_MAX[i]) m_st[i] = 4;
                    end
                end
                m_run[i] = ch ? 1 : m_run[i] + 1;
                m_q[i]   = g[i];
            end
        end
    end

    function automatic logic [54:0] expv(int i);
        return {m_st[i][2:0], m_st[i] >= 2, m_st[i] == 2, m_st[i] == 3, m_st[i] == 4,
                m_cyc[i][31:0], m_chg[i][15:0]};
    endfunction

    // random bus value; a code is only ever emitted for a single cycle
    function automatic logic [15:0] noise(int i, logic [15:0] prev);
        logic [15:0] v = 16'($urandom) & (i < 2 ? 16'h00FF : 16'hFFFF);
        if (prev != P_PASS[i] && prev != P_FAIL[i] && $urandom_range(7) == 0)
            return $urandom_range(1) == 1 ? P_PASS[i] : P_FAIL[i];
        if (v == P_PASS[i] || v == P_FAIL[i]) v = v ^ 16'h0001;
        return v;
    endfunction

    task automatic reset_dut(int i);
        rst[i] = 1'b1;
        #1;
        checks++;
        if (obs[i] !== 55'd0) begin errs++; $display("FAIL reset_async dut%0d got=%h want=0", i, obs[i]); end
        @(negedge clk);
        checks++;
        if (obs[i] !== expv(i)) begin errs++; $display("FAIL reset_hold dut%0d got=%h want=%h", i, obs[i], expv(i)); end
        rst[i] = 1'b0;
    endtask

    task automatic test_reset();
        g[0] = '0; g[2] = '0;
        reset_dut(0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (obs[0] !== expv(0)) begin errs++; $display("FAIL arm_model k=%0d got=%h want=%h", k, obs[0], expv(0)); end
            checks++;
            if (st0 !== (k < 5 ? 3'd0 : 3'd1)) begin errs++; $display("FAIL arm_state k=%0d got=%0d want=%0d", k, st0, k < 5 ? 0 : 1); end
        end
        rst[0] = 1'b1;
        reset_dut(2);
        @(negedge clk);
        checks++;
        if (st2 !== 3'd1) begin errs++; $display("FAIL arm0_state got=%0d want=1", st2); end
        rst[2] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int k = 0;
        g[0] = '0; en[0] = 1'b1;
        reset_dut(0);
        while (!to0 && k < 1100) begin
            @(negedge clk);
            k++;
            checks++;
            if (obs[0] !== expv(0)) begin errs++; $display("FAIL timeout_model k=%0d got=%h want=%h", k, obs[0], expv(0)); end
        end
        checks++;
        if (k >= 1100) begin errs++; $display("FAIL timeout_wait got=no_timeout want=timeout"); end
        checks++;
        if ({dn0, ps0, fl0, to0} !== 4'b1001) begin errs++; $display("FAIL timeout_flags got=%b want=1001", {dn0, ps0, fl0, to0}); end
        checks++;
        if (cc0 !== 32'd1000) begin errs++; $display("FAIL timeout_count got=%0d want=1000", cc0); end
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            checks++;
            if (st0 !== 3'd4 || cc0 !== 32'd1000) begin errs++; $display("FAIL timeout_sticky j=%0d got=%0d/%0d want=4/1000", j, st0, cc0); end
        end
    endtask

    task automatic test_pass();
        int n = 0;
        g[0] = '0; en[0] = 1'b1;
        reset_dut(0);
        while (m_cyc[0] != 100 && n < 200) begin
            @(negedge clk);
            n++;
            checks++;
            if (obs[0] !== expv(0)) begin errs++; $display("FAIL pass_model n=%0d got=%h want=%h", n, obs[0], expv(0)); end
        end
        g[0] = P_PASS[0];
        n = 0;
        while (!ps0 && n < 10) begin
            @(negedge clk);
            n++;
            checks++;
            if (obs[0] !== expv(0)) begin errs++; $display("FAIL pass_lat_model n=%0d got=%h want=%h", n, obs[0], expv(0)); end
        end
        checks++;
        if (n !== 3) begin errs++; $display("FAIL pass_latency got=%0d want=3", n); end
        checks++;
        if (cc0 !== 32'd102 || ch0 !== 16'd1 || dn0 !== 1'b1) begin
            errs++; $display("FAIL pass_counts got=%0d/%0d/%b want=102/1/1", cc0, ch0, dn0);
        end
    endtask

    task automatic test_glitch_fail();
        int n = 0;
        g[0] = '0; en[0] = 1'b1;
        reset_dut(0);
        while (m_st[0] != 1 && n < 20) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        g[0] = P_FAIL[0];
        @(negedge clk);
        g[0] = '0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            checks++;
            if (obs[0] !== expv(0) || fl0 !== 1'b0) begin errs++; $display("FAIL glitch_model j=%0d got=%h want=%h", j, obs[0], expv(0)); end
        end
        checks++;
        if (ch0 !== 16'd2) begin errs++; $display("FAIL glitch_changes got=%0d want=2", ch0); end
        for (int j = 0; j < 40; j++) begin
            g[0] = noise(0, g[0]);
            @(negedge clk);
            checks++;
            if (obs[0] !== expv(0)) begin errs++; $display("FAIL noise_model j=%0d got=%h want=%h", j, obs[0], expv(0)); end
        end
        g[0] = '0;
        @(negedge clk);
        g[0] = P_FAIL[0];
        n = 0;
        while (!fl0 && n < 10) begin
            @(negedge clk);
            n++;
            checks++;
            if (obs[0] !== expv(0)) begin errs++; $display("FAIL fail_model n=%0d got=%h want=%h", n, obs[0], expv(0)); end
        end
        checks++;
        if (n !== 3 || {dn0, ps0, fl0, to0} !== 4'b1010) begin
            errs++; $display("FAIL fail_flags got=%0d/%b want=3/1010", n, {dn0, ps0, fl0, to0});
        end
    endtask

    task automatic test_budget_edge();
        int n = 0;
        g[1] = '0; en[1] = 1'b1;
        reset_dut(1);
        while (m_cyc[1] != 7 && n < 30) begin @(negedge clk); n++; end
        g[1] = P_PASS[1];
        n = 0;
        while (!dn1 && n < 10) begin
            @(negedge clk);
            n++;
            checks++;
            if (obs[1] !== expv(1)) begin errs++; $display("FAIL edge_model n=%0d got=%h want=%h", n, obs[1], expv(1)); end
        end
        checks++;
        if ({ps1, to1} !== 2'b10 || cc1 !== 32'd9) begin
            errs++; $display("FAIL edge_pass_wins got=%b/%0d want=10/9", {ps1, to1}, cc1);
        end
        g[1] = '0;
        reset_dut(1);
        n = 0;
        while (!dn1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if ({ps1, to1} !== 2'b01 || cc1 !== 32'd10 || n !== 15) begin
            errs++; $display("FAIL edge_timeout got=%b/%0d/%0d want=01/10/15", {ps1, to1}, cc1, n);
        end
        rst[1] = 1'b1;
    endtask

    task automatic test_enable_freeze();
        int k = 0;
        g[0] = '0; en[0] = 1'b1;
        reset_dut(0);
        while (!to0 && k < 1200) begin
            @(negedge clk);
            k++;
            checks++;
            if (obs[0] !== expv(0)) begin errs++; $display("FAIL freeze_model k=%0d got=%h want=%h", k, obs[0], expv(0)); end
            if (k >= 300 && k <= 320) begin
                checks++;
                if (cc0 !== 32'd295) begin errs++; $display("FAIL freeze_count k=%0d got=%0d want=295", k, cc0); end
            end
            if (k == 300) en[0] = 1'b0;
            if (k == 320) en[0] = 1'b1;
            g[0] = noise(0, g[0]);
        end
        checks++;
        if (k !== 1025 || cc0 !== 32'd1000) begin errs++; $display("FAIL freeze_timeout got=%0d/%0d want=1025/1000", k, cc0); end
        reset_dut(0);
        for (int j = 0; j < 30; j++) begin
            en[0] = 1'($urandom_range(1));
            g[0] = noise(0, g[0]);
            @(negedge clk);
        end
        reset_dut(0);
        g[0] = '0; en[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            checks++;
            if (obs[0] !== expv(0)) begin errs++; $display("FAIL rerun_model j=%0d got=%h want=%h", j, obs[0], expv(0)); end
        end
        rst[0] = 1'b1;
    endtask

    task automatic test_wide();
        int idle;
        g[2] = P_PASS[2];
        repeat (2) @(negedge clk);
        g[2] = '0;
        reset_dut(2);
        idle = $urandom_range(12, 4);
        g[2] = 16'h00FE;
        for (int j = 0; j < idle; j++) begin
            @(negedge clk);
            checks++;
            if (obs[2] !== expv(2) || ps2 !== 1'b0) begin errs++; $display("FAIL wide_idle j=%0d got=%h want=%h", j, obs[2], expv(2)); end
        end
        g[2] = P_PASS[2];
        @(negedge clk);
        checks++;
        if (ps2 !== 1'b0) begin errs++; $display("FAIL wide_early got=%b want=0", ps2); end
        @(negedge clk);
        checks++;
        if ({dn2, ps2, fl2, to2} !== 4'b1100 || obs[2] !== expv(2)) begin
            errs++; $display("FAIL wide_pass got=%b want=1100", {dn2, ps2, fl2, to2});
        end
        g[2] = '0;
        reset_dut(2);
        repeat ($urandom_range(6, 2)) @(negedge clk);
        g[2] = P_FAIL[2];
        repeat (2) @(negedge clk);
        checks++;
        if ({dn2, ps2, fl2, to2} !== 4'b1010 || obs[2] !== expv(2)) begin
            errs++; $display("FAIL wide_fail got=%b want=1010", {dn2, ps2, fl2, to2});
        end
        rst[2] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin rst[i] = 1'b1; en[i] = 1'b1; g[i] = '0; end
        repeat (2) @(negedge clk);
        test_reset();
        test_timeout();
        test_pass();
        test_glitch_fail();
        test_budget_edge();
        test_enable_freeze();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end
endmodule
